// File: rtl/nco_if.sv
// NCO control/sample bundle between the I2C control slave side and the core.
// Master drives the programming fields, slave returns the waveform samples.
interface nco_if #(
  parameter int ACC_W  = 64,
  parameter int DUTY_W = 16,
  parameter int OUT_W  = 12
);
  logic              enable;
  logic [1:0]        wave;
  logic [ACC_W-1:0]  frequency;
  logic [DUTY_W-1:0] duty_cycle;
  logic [OUT_W-1:0]  wave_out;
  logic              square_out;
  logic              sync_pulse;
  logic              running;

  modport master (
    output enable, wave, frequency, duty_cycle,
    input  wave_out, square_out, sync_pulse, running
  );

  modport slave (
    input  enable, wave, frequency, duty_cycle,
    output wave_out, square_out, sync_pulse, running
  );
endinterface

// File: rtl/nco_waveform_core.sv
// Phase-accumulator waveform generator: square/saw/triangle samples with
// settings latched only at period boundaries so the output never glitches.
module nco_waveform_core #(
  parameter int ACC_W  = 64,
  parameter int DUTY_W = 16,
  parameter int OUT_W  = 12
) (
  input logic clk,
  input logic reset,
  nco_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  freq_a;
  logic [DUTY_W-1:0] duty_a;
  logic [1:0]        wave_a;

  logic [ACC_W:0]    sum;
  logic              wrap;
  logic              zero_f;
  logic              load;
  logic              stop;
  logic              sq;
  logic [OUT_W-1:0]  p;
  logic [OUT_W-1:0]  t;
  logic [OUT_W-1:0]  sample;

  // Phase step and the sample shape derived from the current phase
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, freq_a};
    wrap   = sum[ACC_W];
    zero_f = (freq_a == '0);
    p      = acc[ACC_W-1 -: OUT_W];
    t      = acc[ACC_W-2 -: OUT_W];
    sq     = (acc[ACC_W-1 -: DUTY_W] < duty_a);
    sample = '0;
    unique case (wave_a)
      2'b00: sample = sq ? {OUT_W{1'b1}} : '0;
      2'b01: sample = p;
      2'b10: sample = acc[ACC_W-1] ? ~t : t;
      2'b11: sample = ~p;
      default: sample = '0;
    endcase
  end

  // Next state, load points and the park decision
  always_comb begin
    nxt  = state;
    load = 1'b0;
    stop = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          nxt  = RUN;
          load = 1'b1;
        end
      end
      RUN: begin
        if (!bus.enable && zero_f) begin
          stop = 1'b1;
        end else begin
          if (!bus.enable) nxt = STOPPING;
          load = wrap || zero_f;
        end
      end
      STOPPING: begin
        if (bus.enable) begin
          nxt  = RUN;
          load = wrap;
        end else if (wrap || zero_f) begin
          stop = 1'b1;
        end
      end
      default: stop = 1'b1;
    endcase
    if (stop) nxt = IDLE;
  end

  // State, accumulator, active settings and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      acc            <= '0;
      freq_a         <= '0;
      duty_a         <= '0;
      wave_a         <= '0;
      bus.wave_out   <= '0;
      bus.square_out <= 1'b0;
      bus.sync_pulse <= 1'b0;
      bus.running    <= 1'b0;
    end else begin
      state       <= nxt;
      bus.running <= (nxt != IDLE);
      if (state == IDLE || stop) begin
        acc            <= '0;
        bus.wave_out   <= '0;
        bus.square_out <= 1'b0;
        bus.sync_pulse <= 1'b0;
      end else begin
        acc            <= sum[ACC_W-1:0];
        bus.wave_out   <= sample;
        bus.square_out <= sq;
        bus.sync_pulse <= wrap;
      end
      if (load) begin
        freq_a <= bus.frequency;
        duty_a <= bus.duty_cycle;
        wave_a <= bus.wave;
      end
    end
  end

endmodule

// File: tb/tb_nco_waveform_core.sv
// Random and directed checks of nco_waveform_core against a phase model.
// The model tracks phase as a plain 64-bit number and derives samples arithmetically.
module tb_nco_waveform_core;

  localparam logic [63:0] F60 = 64'd1 << 60;
  localparam logic [63:0] F59 = 64'd1 << 59;
  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MS = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  nco_if #(.ACC_W(64), .DUTY_W(16), .OUT_W(12)) bus ();

  nco_waveform_core #(.ACC_W(64), .DUTY_W(16), .OUT_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          m_mode;
  logic [63:0] m_acc;
  logic [63:0] m_f;
  logic [15:0] m_d;
  logic [1:0]  m_w;
  logic [11:0] m_wo;
  logic        m_sq;
  logic        m_sy;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit high_part(input logic [63:0] a, input logic [15:0] d);
    int unsigned frac;
    frac = 32'(a >> 48);
    return frac < 32'(d);
  endfunction

  function automatic logic [11:0] shape(input logic [63:0] a,
                                        input logic [1:0] w,
                                        input logic [15:0] d);
    int unsigned pos;
    int unsigned x;
    int unsigned v;
    pos = 32'(a >> 52);
    x   = 32'(a >> 51);
    case (w)
      2'd0:    v = high_part(a, d) ? 4095 : 0;
      2'd1:    v = pos;
      2'd2:    v = (x < 4096) ? x : 8191 - x;
      default: v = 4095 - pos;
    endcase
    return 12'(v);
  endfunction

  // Advance the model by one clock using the inputs as they are now.
  task automatic model_step();
    logic [63:0] nx;
    bit wrap;
    bit load;
    bit park;
    int nm;
    nx   = m_acc + m_f;
    wrap = (nx < m_acc);
    load = 0;
    park = 0;
    nm   = m_mode;
    if (!reset) begin
      m_mode = MI; m_acc = 0; m_f = 0; m_d = 0; m_w = 0;
      m_wo = 0; m_sq = 0; m_sy = 0;
      return;
    end
    if (m_mode == MI) begin
      if (bus.enable) begin nm = MR; load = 1; end
    end else if (m_mode == MR) begin
      if (!bus.enable && m_f == 0) park = 1;
      else begin
        if (!bus.enable) nm = MS;
        load = wrap || (m_f == 0);
      end
    end else begin
      if (bus.enable) begin nm = MR; load = wrap; end
      else if (wrap || m_f == 0) park = 1;
    end
    if (park) nm = MI;
    if (m_mode == MI || park) begin
      m_wo = 0; m_sq = 0; m_sy = 0; m_acc = 0;
    end else begin
      m_wo  = shape(m_acc, m_w, m_d);
      m_sq  = high_part(m_acc, m_d);
      m_sy  = wrap;
      m_acc = nx;
    end
    if (load) begin
      m_f = bus.frequency; m_d = bus.duty_cycle; m_w = bus.wave;
    end
    m_mode = nm;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("wave_out", 64'(bus.wave_out), 64'(m_wo));
    chk("square_out", 64'(bus.square_out), 64'(m_sq));
    chk("sync_pulse", 64'(bus.sync_pulse), 64'(m_sy));
    chk("running", 64'(bus.running), 64'(m_mode != MI));
  endtask

  task automatic wait_sync(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (bus.sync_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (bus.square_out) n++;
    end
  endtask

  initial begin
    int n;
    n_chk          = 0;
    n_pass         = 0;
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.wave       = 2'b01;
    bus.frequency  = F60;
    bus.duty_cycle = 16'h8000;
    model_step();

    // reset held with enable high
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_running", 64'(bus.running), 64'd0);
      chk("rst_wave", 64'(bus.wave_out), 64'd0);
    end
    reset = 1'b1;
    cyc();
    chk("start_running", 64'(bus.running), 64'd1);

    // saw up staircase and sync spacing
    for (int i = 0; i < 32; i++) begin
      cyc();
      chk("saw_step", 64'(bus.wave_out), 64'((i % 16) * 256));
      chk("saw_sync", 64'(bus.sync_pulse), 64'(i % 16 == 15));
    end

    // square duty sweep
    bus.wave = 2'b00;
    for (int i = 0; i < 20; i++) cyc();
    count_high(n);
    chk("duty_half", 64'(n), 64'd8);
    bus.duty_cycle = 16'h0000;
    for (int i = 0; i < 20; i++) cyc();
    count_high(n);
    chk("duty_zero", 64'(n), 64'd0);
    bus.duty_cycle = 16'hFFFF;
    for (int i = 0; i < 20; i++) cyc();
    count_high(n);
    chk("duty_full", 64'(n), 64'd16);

    // frequency/wave change deferred to the wrap
    wait_sync(n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 6) begin
        bus.frequency = F59;
        bus.wave      = 2'b01;
      end
      cyc();
      if (bus.sync_pulse) begin
        n = i;
        break;
      end
    end
    chk("period_old", 64'(n), 64'd16);
    wait_sync(n);
    chk("period_new", 64'(n), 64'd32);

    // stop at phase 5/16 finishes the period
    bus.frequency = F60;
    wait_sync(n);
    wait_sync(n);
    for (int i = 0; i < 5; i++) cyc();
    bus.enable = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (!bus.running) begin
        n = i;
        break;
      end
    end
    chk("stop_len", 64'(n), 64'd11);
    chk("stop_out", 64'(bus.wave_out), 64'd0);

    // re-enable while stopping keeps phase
    bus.enable = 1'b1;
    cyc();
    wait_sync(n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) bus.enable = 1'b0;
      if (i == 9) bus.enable = 1'b1;
      cyc();
      if (bus.sync_pulse) begin
        n = i;
        break;
      end
    end
    chk("reenable_period", 64'(n), 64'd16);

    // zero tuning word: immediate reload, immediate park
    bus.frequency = 64'd0;
    wait_sync(n);
    for (int i = 0; i < 3; i++) cyc();
    chk("freq0_hold", 64'(bus.wave_out), 64'd0);
    bus.frequency = F60;
    cyc();
    cyc();
    cyc();
    chk("freq0_resume", 64'(bus.wave_out), 64'd256);
    bus.frequency = 64'd0;
    wait_sync(n);
    cyc();
    bus.enable = 1'b0;
    cyc();
    chk("freq0_park", 64'(bus.running), 64'd0);

    // randomized programming, enable toggling and occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        bus.enable = ($urandom_range(0, 4) != 0);
        bus.wave   = 2'($urandom_range(0, 3));
        bus.duty_cycle = 16'($urandom);
        case ($urandom_range(0, 3))
          0: bus.frequency = 64'd0;
          1: bus.frequency = 64'd1 << $urandom_range(56, 62);
          2: bus.frequency = {$urandom, $urandom} >> $urandom_range(1, 6);
          default: bus.frequency = {32'($urandom_range(1, 255)), 32'($urandom)} << 24;
        endcase
      end
      reset = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
